// File: rtl/bcd_calc_serial.sv
// bcd_calc_serial
//   Keypad-entry BCD calculator core. Two decimal operands are typed digit
//   by digit and latched with the store strobe. They are then added or
//   subtracted by a digit-serial BCD datapath that handles one digit per
//   clock, least significant digit first.
//
// Ports
//   i_clk                clock, rising edge
//   i_rst                asynchronous active-high reset
//   i_push               digit strobe (rising edge = one digit)
//   i_entrada[3:0]       digit value, sampled with the push edge
//   i_guardar            store strobe (rising edge latches current operand)
//   i_restar             0 = A+B, 1 = A-B, sampled when B is latched
//   i_finalizar          synchronous clear back to entry of A, top priority
//   o_numero             operand being typed, packed BCD, LSD in [3:0]
//   o_resultado          result magnitude, DIGITS+1 packed BCD digits
//   o_negativo           result sign (subtract only)
//   o_resultado_valido   high while o_resultado is final
//   o_ocupado            high while the serial datapath runs
//   o_error_digito       one-cycle pulse on a push edge with entrada > 9
module bcd_calc_serial #(
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [3:0]            i_entrada,
    input  logic                  i_guardar,
    input  logic                  i_restar,
    input  logic                  i_finalizar,
    output logic [4*DIGITS-1:0]   o_numero,
    output logic [4*DIGITS+3:0]   o_resultado,
    output logic                  o_negativo,
    output logic                  o_resultado_valido,
    output logic                  o_ocupado,
    output logic                  o_error_digito
);

    localparam int NW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {ENT_A, ENT_B, CALC, DONE} state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_armed;
    logic            r_push_d;
    logic            r_guardar_d;
    logic [NW-1:0]   r_numero;
    logic [CW-1:0]   r_cnt;
    logic [NW-1:0]   r_a;
    logic [NW-1:0]   r_b;
    logic            r_sub;
    logic            r_neg;
    logic [NW+3:0]   r_res;
    logic            r_cy;
    logic [IW-1:0]   r_idx;
    logic            r_err;

    logic            w_push_edge;
    logic            w_guardar_edge;
    logic            w_dig_ok;
    logic            w_accept;
    logic [NW-1:0]   w_num_next;
    logic            w_last;
    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [4:0]      w_dig;

    // One BCD digit of A+B+c; returns {carry, digit}.
    function automatic logic [4:0] add_dig(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0, c};
        if (s > 5'd9) return {1'b1, 4'(s + 5'd6)};
        return {1'b0, s[3:0]};
    endfunction

    // One BCD digit of x-y-bw; returns {borrow, digit}.
    function automatic logic [4:0] sub_dig(input logic [3:0] x, input logic [3:0] y,
                                           input logic bw);
        logic signed [5:0] d;
        d = $signed({2'b0, x}) - $signed({2'b0, y}) - $signed({5'b0, bw});
        if (d < 6'sd0) return {1'b1, 4'(d + 6'sd10)};
        return {1'b0, d[3:0]};
    endfunction

    // r_armed masks the first cycle after reset so a strobe already held
    // high when reset releases is not mistaken for a fresh edge.
    assign w_push_edge    = r_armed & i_push & ~r_push_d;
    assign w_guardar_edge = r_armed & i_guardar & ~r_guardar_d;
    assign w_dig_ok       = (i_entrada <= 4'd9);
    assign w_accept       = w_push_edge & w_dig_ok & (r_cnt < CW'(DIGITS));
    assign w_num_next     = w_accept ? NW'({r_numero, i_entrada}) : r_numero;

    assign w_last  = (r_idx == IW'(DIGITS - 1));
    assign w_a_dig = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_dig = r_b[{r_idx, 2'b00} +: 4];
    assign w_dig   = r_sub ? sub_dig(w_a_dig, w_b_dig, r_cy)
                           : add_dig(w_a_dig, w_b_dig, r_cy);

    assign o_numero           = r_numero;
    assign o_resultado        = r_res;
    assign o_negativo         = r_neg;
    assign o_error_digito     = r_err;
    assign o_ocupado          = (r_state == CALC);
    assign o_resultado_valido = (r_state == DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ENT_A;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_finalizar) begin
            w_next = ENT_A;
        end else begin
            case (r_state)
                ENT_A:   if (w_guardar_edge) w_next = ENT_B;
                ENT_B:   if (w_guardar_edge) w_next = CALC;
                CALC:    if (w_last)         w_next = DONE;
                DONE:    if (w_push_edge)    w_next = ENT_A;
                default: w_next = ENT_A;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_armed     <= 1'b0;
            r_push_d    <= 1'b0;
            r_guardar_d <= 1'b0;
            r_numero    <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_neg       <= 1'b0;
            r_res       <= '0;
            r_cy        <= 1'b0;
            r_idx       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_push_d    <= i_push;
            r_guardar_d <= i_guardar;
            r_err       <= 1'b0;
            if (i_finalizar) begin
                r_numero <= '0;
                r_cnt    <= '0;
                r_a      <= '0;
                r_b      <= '0;
                r_sub    <= 1'b0;
                r_neg    <= 1'b0;
                r_res    <= '0;
                r_cy     <= 1'b0;
                r_idx    <= '0;
            end else begin
                case (r_state)
                    ENT_A, ENT_B: begin
                        if (w_push_edge && !w_dig_ok) r_err <= 1'b1;
                        if (w_guardar_edge) begin
                            // A digit arriving on the same edge is already in w_num_next.
                            r_numero <= '0;
                            r_cnt    <= '0;
                            if (r_state == ENT_A) begin
                                r_a <= w_num_next;
                            end else begin
                                r_sub <= i_restar;
                                r_idx <= '0;
                                r_cy  <= 1'b0;
                                r_res <= '0;
                                // Subtract always runs larger-minus-smaller; sign kept aside.
                                if (i_restar && (r_a < w_num_next)) begin
                                    r_a   <= w_num_next;
                                    r_b   <= r_a;
                                    r_neg <= 1'b1;
                                end else begin
                                    r_b   <= w_num_next;
                                    r_neg <= 1'b0;
                                end
                            end
                        end else begin
                            r_numero <= w_num_next;
                            if (w_accept) r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    CALC: begin
                        r_res[{r_idx, 2'b00} +: 4] <= w_dig[3:0];
                        r_cy  <= w_dig[4];
                        r_idx <= r_idx + IW'(1);
                        if (w_last) r_res[NW +: 4] <= r_sub ? 4'd0 : {3'b0, w_dig[4]};
                    end
                    DONE: begin
                        if (w_push_edge) begin
                            r_res <= '0;
                            r_neg <= 1'b0;
                            r_sub <= 1'b0;
                            if (w_dig_ok) begin
                                r_numero <= NW'(i_entrada);
                                r_cnt    <= CW'(1);
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_calc_serial.sv
module tb_bcd_calc_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        guardar = 1'b0;
    logic        restar = 1'b0;
    logic        finalizar = 1'b0;
    logic [3:0]  entrada = 4'd0;

    logic [11:0] w3_numero;
    logic [15:0] w3_res;
    logic        w3_neg, w3_vld, w3_busy, w3_err;
    logic [19:0] w5_numero;
    logic [23:0] w5_res;
    logic        w5_neg, w5_vld, w5_busy, w5_err;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_calc_serial #(.DIGITS(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_push(push), .i_entrada(entrada),
        .i_guardar(guardar), .i_restar(restar), .i_finalizar(finalizar),
        .o_numero(w3_numero), .o_resultado(w3_res), .o_negativo(w3_neg),
        .o_resultado_valido(w3_vld), .o_ocupado(w3_busy), .o_error_digito(w3_err)
    );

    bcd_calc_serial #(.DIGITS(5)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_push(push), .i_entrada(entrada),
        .i_guardar(guardar), .i_restar(restar), .i_finalizar(finalizar),
        .o_numero(w5_numero), .o_resultado(w5_res), .o_negativo(w5_neg),
        .o_resultado_valido(w5_vld), .o_ocupado(w5_busy), .o_error_digito(w5_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        entrada = d;
        push = 1'b1;
        tick();
        push = 1'b0;
        tick();
    endtask

    task automatic store();
        guardar = 1'b1;
        tick();
        guardar = 1'b0;
        tick();
    endtask

    task automatic clear();
        finalizar = 1'b1;
        tick();
        finalizar = 1'b0;
        tick();
    endtask

    // Latch B and follow the 3-digit serial run edge by edge.
    task automatic calc3(input string tag, input logic r, input logic [15:0] exp_res,
                         input logic exp_neg);
        restar = r;
        guardar = 1'b1;
        tick();
        check_eq({tag, "_busy"}, w3_busy, 1'b1);
        guardar = 1'b0;
        restar = 1'b0;
        tick();
        tick();
        check_eq({tag, "_early_vld"}, w3_vld, 1'b0);
        tick();
        check_eq({tag, "_vld"}, w3_vld, 1'b1);
        check_eq({tag, "_idle"}, w3_busy, 1'b0);
        check_eq({tag, "_res"}, w3_res, exp_res);
        check_eq({tag, "_neg"}, w3_neg, exp_neg);
    endtask

    initial begin
        // Reset with both strobes held high across release.
        push = 1'b1;
        guardar = 1'b1;
        tick();
        tick();
        check_eq("rst_numero", w3_numero, 12'h000);
        check_eq("rst_res", w3_res, 16'h0000);
        check_eq("rst_ctrl", {w3_neg, w3_vld, w3_busy, w3_err}, 4'b0000);
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst_held_push", w3_numero, 12'h000);
        push = 1'b0;
        guardar = 1'b0;
        tick();

        // 357 + 421
        key(4'd3); key(4'd5); key(4'd7);
        check_eq("t1_numero", w3_numero, 12'h357);
        store();
        check_eq("t1_numero_clr", w3_numero, 12'h000);
        key(4'd4); key(4'd2); key(4'd1);
        calc3("t1", 1'b0, 16'h0778, 1'b0);

        // 999 + 1, then 0 + 0 with no digits typed
        clear();
        check_eq("t2_clr_vld", w3_vld, 1'b0);
        check_eq("t2_clr_res", w3_res, 16'h0000);
        key(4'd9); key(4'd9); key(4'd9);
        store();
        key(4'd1);
        calc3("t2a", 1'b0, 16'h1000, 1'b0);
        clear();
        store();
        calc3("t2b", 1'b0, 16'h0000, 1'b0);

        // 123 - 456 and 500 - 500
        clear();
        key(4'd1); key(4'd2); key(4'd3);
        store();
        key(4'd4); key(4'd5); key(4'd6);
        calc3("t3a", 1'b1, 16'h0333, 1'b1);
        clear();
        check_eq("t3_clr_neg", w3_neg, 1'b0);
        key(4'd5); key(4'd0); key(4'd0);
        store();
        key(4'd5); key(4'd0); key(4'd0);
        calc3("t3b", 1'b1, 16'h0000, 1'b0);

        // Digit saturation, held push, bad digit
        clear();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        check_eq("t4_sat", w3_numero, 12'h123);
        clear();
        entrada = 4'd7;
        push = 1'b1;
        repeat (5) tick();
        push = 1'b0;
        tick();
        check_eq("t4_hold", w3_numero, 12'h007);
        entrada = 4'd10;
        push = 1'b1;
        tick();
        check_eq("t4_err_on", w3_err, 1'b1);
        push = 1'b0;
        tick();
        check_eq("t4_err_off", w3_err, 1'b0);
        check_eq("t4_err_numero", w3_numero, 12'h007);

        // finalizar during CALC
        clear();
        key(4'd2); key(4'd4); key(4'd6);
        store();
        key(4'd1); key(4'd1); key(4'd1);
        guardar = 1'b1;
        tick();
        guardar = 1'b0;
        finalizar = 1'b1;
        tick();
        finalizar = 1'b0;
        check_eq("t5_fin_busy", w3_busy, 1'b0);
        check_eq("t5_fin_vld", w3_vld, 1'b0);
        check_eq("t5_fin_res", w3_res, 16'h0000);
        repeat (4) tick();
        check_eq("t5_fin_stay", w3_vld, 1'b0);

        // Asynchronous reset mid-entry
        key(4'd5); key(4'd6);
        check_eq("t5_pre_rst", w3_numero, 12'h056);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_numero", w3_numero, 12'h000);
        check_eq("t5_rst_ctrl", {w3_neg, w3_vld, w3_busy, w3_err}, 4'b0000);
        tick();
        rst = 1'b0;
        tick();

        // DIGITS=5: 99999 + 99999, then a new digit in DONE
        clear();
        repeat (5) key(4'd9);
        check_eq("t6_numero", w5_numero, 20'h99999);
        store();
        repeat (5) key(4'd9);
        guardar = 1'b1;
        tick();
        check_eq("t6_busy", w5_busy, 1'b1);
        guardar = 1'b0;
        repeat (4) tick();
        check_eq("t6_early_vld", w5_vld, 1'b0);
        tick();
        check_eq("t6_vld", w5_vld, 1'b1);
        check_eq("t6_res", w5_res, 24'h199998);
        check_eq("t6_neg", w5_neg, 1'b0);
        key(4'd4);
        check_eq("t6_new_a", w5_numero, 20'h00004);
        check_eq("t6_new_vld", w5_vld, 1'b0);
        check_eq("t6_new_res", w5_res, 24'h000000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
